// File: rtl/pt_check.sv
// pt_check: scans a length-prefixed plaintext buffer after an ARC4 decrypt
// and reports whether every payload byte is printable. Byte 0 holds the
// length L; bytes 1..L are each compared against [LO, HI]. The scan stops
// at the first illegal byte. Results are returned over an en/rdy handshake.
module pt_check #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       valid,
    output logic [7:0] bad_idx,
    output logic [7:0] len
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LEN_ADDR  = 3'd1,
        S_LEN_DATA  = 3'd2,
        S_BYTE_ADDR = 3'd3,
        S_BYTE_DATA = 3'd4
    } state_t;

    state_t     state_q,   state_d;
    logic       rdy_q,     rdy_d;
    logic       valid_q,   valid_d;
    logic [7:0] bad_idx_q, bad_idx_d;
    logic [7:0] len_q,     len_d;
    logic [7:0] pt_addr_q, pt_addr_d;
    logic [7:0] idx_q,     idx_d;

    // Unsigned inclusive range test for one plaintext byte.
    function automatic logic byte_legal(input logic [7:0] b);
        return (b >= LO) && (b <= HI);
    endfunction

    // Next-state and next-output logic. The address register is loaded on
    // the transition into an ADDR state so the RAM sees it for the whole
    // ADDR cycle and the read data arrives in the following DATA cycle.
    always_comb begin
        state_d   = state_q;
        rdy_d     = rdy_q;
        valid_d   = valid_q;
        bad_idx_d = bad_idx_q;
        len_d     = len_q;
        pt_addr_d = pt_addr_q;
        idx_d     = idx_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    valid_d   = 1'b0;
                    bad_idx_d = 8'd0;
                    len_d     = 8'd0;
                    idx_d     = 8'd0;
                    pt_addr_d = 8'd0;
                    rdy_d     = 1'b0;
                    state_d   = S_LEN_ADDR;
                end
            end

            S_LEN_ADDR: begin
                state_d = S_LEN_DATA;
            end

            S_LEN_DATA: begin
                len_d = pt_rddata;
                if (pt_rddata == 8'd0) begin
                    // Empty string is trivially legal.
                    valid_d = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d     = 8'd1;
                    pt_addr_d = 8'd1;
                    state_d   = S_BYTE_ADDR;
                end
            end

            S_BYTE_ADDR: begin
                state_d = S_BYTE_DATA;
            end

            S_BYTE_DATA: begin
                if (!byte_legal(pt_rddata)) begin
                    bad_idx_d = idx_q;
                    valid_d   = 1'b0;
                    rdy_d     = 1'b1;
                    state_d   = S_IDLE;
                end else if (idx_q == len_q) begin
                    // Compared before incrementing so L=255 never wraps.
                    valid_d   = 1'b1;
                    bad_idx_d = 8'd0;
                    rdy_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    idx_d     = idx_q + 8'd1;
                    pt_addr_d = idx_q + 8'd1;
                    state_d   = S_BYTE_ADDR;
                end
            end

            default: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b1;
            valid_q   <= 1'b0;
            bad_idx_q <= 8'd0;
            len_q     <= 8'd0;
            pt_addr_q <= 8'd0;
            idx_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            valid_q   <= valid_d;
            bad_idx_q <= bad_idx_d;
            len_q     <= len_d;
            pt_addr_q <= pt_addr_d;
            idx_q     <= idx_d;
        end
    end

    assign rdy     = rdy_q;
    assign valid   = valid_q;
    assign bad_idx = bad_idx_q;
    assign len     = len_q;
    assign pt_addr = pt_addr_q;

endmodule

// File: doc/pt_check.md
Name: pt_check

Overview:
- Downstream consumer of the ARC4 decrypt/crack datapath.
- After a candidate key has decrypted the ciphertext into plaintext memory, this block scans that memory and decides whether the candidate plaintext is legal.
- The plaintext is a length-prefixed string: byte 0 holds the length L, and bytes 1..L must all lie in the printable ASCII range.
- Result (valid flag, first offending index, length) is returned to the crack controller over the standard en/rdy handshake.

Parameters:
- LO, 8'h20: lowest legal byte value (inclusive).
- HI, 8'h7E: highest legal byte value (inclusive).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request; sampled only on a posedge where rdy=1.
- rdy  output  1  1 = idle and results stable; 0 = check in progress.
- pt_addr  output  8  address to plaintext memory (synchronous-read RAM, 1-cycle read latency).
- pt_rddata  input  8  read data from plaintext memory.
- valid  output  1  1 = last completed check found every byte in [LO,HI].
- bad_idx  output  8  index (1..255) of the first illegal byte; 0 when valid=1.
- len  output  8  length byte read at address 0 during the last check.

Behaviour:
- Reset (async, while rst=1): state IDLE, rdy=1, valid=0, bad_idx=0, len=0, pt_addr=0, index counter=0.
- Reset mid-operation aborts the scan immediately. No partial result is retained.
- Memory timing: pt_addr driven in cycle c → pt_rddata valid in cycle c+1. Each byte takes one ADDR cycle and one DATA cycle.
- States:
  - IDLE: rdy=1. On a posedge with en=1: clear valid, bad_idx and len; index=0; go to LEN_ADDR.
  - LEN_ADDR: rdy=0, pt_addr=0 → LEN_DATA.
  - LEN_DATA: latch len=pt_rddata.
    - If pt_rddata==0: valid=1 → IDLE.
    - Otherwise index=1 → BYTE_ADDR.
  - BYTE_ADDR: pt_addr=index → BYTE_DATA.
  - BYTE_DATA: test LO <= pt_rddata <= HI (unsigned).
    - Fail: bad_idx=index, valid=0 → IDLE (early abort).
    - Pass and index==len: valid=1, bad_idx=0 → IDLE.
    - Pass otherwise: index+1 → BYTE_ADDR.
- Latency, counting the en-accept edge as edge 0:
  - All bytes legal: rdy returns high in cycle 3+2L.
  - Early abort at index k: rdy returns high in cycle 3+2k.
  - L=0: rdy returns high in cycle 3.
- The index never wraps. The index==len test comes before the increment, so L=255 ends at index 255 with no overflow.
- en while rdy=0 is ignored and not queued.
- en held high continuously: a new check starts on every edge where rdy=1, giving back-to-back checks with one IDLE cycle between them.
- valid, bad_idx and len:
  - change only in LEN_DATA and BYTE_DATA, and at acceptance (cleared);
  - are held stable while rdy=1 until the next accepted en.
- pt_addr holds its last value outside the ADDR states. No memory writes are issued.

Test Plan:
- Memory = {0x05,"HELLO"}, pulse en → rdy low, then high in cycle 13; valid=1, bad_idx=0, len=5.
- Memory = {0x06,'a','b','c',0x1F,'d','e'}, pulse en → abort at index 4; rdy high in cycle 11; valid=0, bad_idx=4, len=6. Bytes 5..6 are never addressed (monitor pt_addr).
- Boundaries: {0x02,0x20,0x7E} → valid=1. {0x01,0x7F} → valid=0, bad_idx=1. {0x01,0x80} → valid=0, bad_idx=1.
- L=0 ({0x00}) → valid=1, bad_idx=0, rdy high in cycle 3. L=255 with all bytes 'A' → valid=1, rdy high in cycle 513, final pt_addr=255.
- Assert rst during BYTE_DATA at index 3 → rdy=1, valid=0, bad_idx=0, len=0 immediately. A fresh en then completes normally.
- Pulse en again while rdy=0 → ignored; result matches a single check. Hold en=1 across two completions → two checks, each re-reading address 0.
